// File: rtl/bitop16_pkg.sv
// Shared opcode, FSM-state and sizing definitions for the bitop16 arbiter slice.
// Pure declarations: no latency, no backpressure.
package bitop16_pkg;

    localparam logic [1:0] OP_NOT  = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/bitop16_rr_arbiter.sv
// Combinational one-hot grant, round-robin from i_ptr with BITOP16_ARB_RR_EN, else lowest index wins.
// Zero latency; grants only among currently asserted requests.
module bitop16_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
`ifdef BITOP16_ARB_RR_EN
    input  logic [PTR_W-1:0]   i_ptr,
`endif
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx
);

    logic w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
`ifdef BITOP16_ARB_RR_EN
            j = int'(i_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
`else
            j = i;
`endif
            if (!w_found && i_req[j]) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = PTR_W'(j);
                w_found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bitop16_arbiter.sv
// Shares one bitwise logic unit among NUM_REQ requesters; accept->rsp_valid 2 cycles, >=3 cycles/op.
// Holds in RESP while rsp_ready[w] is low; round-robin when BITOP16_ARB_RR_EN is defined, else fixed priority.
module bitop16_arbiter
    import bitop16_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_winner;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_data;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_accept;
    logic               w_rsp_hs;
    logic [WIDTH-1:0]   w_lu_result;

    assign w_any    = |req_valid;
    assign w_accept = (r_state == ST_IDLE) && w_any;
    assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready[r_winner];

`ifdef BITOP16_ARB_RR_EN
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_rsp_hs) begin
            r_ptr <= (int'(r_winner) == NUM_REQ - 1) ? '0 : r_winner + 1'b1;
        end
    end
`endif

    bitop16_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req       (req_valid),
`ifdef BITOP16_ARB_RR_EN
        .i_ptr       (r_ptr),
`endif
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Ready is masked while reset is asserted so no requester sees a grant during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        busy      = (r_state != ST_IDLE);
        if (r_state == ST_IDLE && rst_n) req_ready = w_grant;
        if (r_state == ST_RESP) rsp_valid = NUM_REQ'(1) << r_winner;
    end

    always_comb begin
        w_lu_result = '0;
        case (r_op)
            OP_NOT:  w_lu_result = ~r_a;
            OP_AND:  w_lu_result = r_a & r_b;
            OP_OR:   w_lu_result = r_a | r_b;
            OP_NAND: w_lu_result = ~(r_a & r_b);
            default: w_lu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner <= '0;
            r_op     <= OP_NOT;
            r_a      <= '0;
            r_b      <= '0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                r_winner <= w_gidx;
                r_op     <= req_op[int'(w_gidx)*2 +: 2];
                r_a      <= req_a[int'(w_gidx)*WIDTH +: WIDTH];
                r_b      <= req_b[int'(w_gidx)*WIDTH +: WIDTH];
            end
            if (r_state == ST_EXEC) r_data <= w_lu_result;
        end
    end

    assign rsp_data = r_data;

endmodule

// File: doc/bitop16_arbiter.md
# bitop16_arbiter

Shared-resource controller for one 16-bit bitwise logic unit (Not/And/Or/Nand over 16 bits) serving several requesters. Arbitrates incoming operation requests, captures operands, executes on the single unit, and returns a registered result to the winning requester over a valid/ready handshake. Sits between the CPU-side bus clients and the gate-level 16-bit logic datapath, so only one copy of that datapath is instantiated.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_op  in  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]
- req_a  in  WIDTH*NUM_REQ  per-requester operand a
- req_b  in  WIDTH*NUM_REQ  per-requester operand b (ignored for NOT)
- rsp_valid  out  NUM_REQ  per-requester response valid; at most one bit high
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  WIDTH  shared result bus, meaningful only where rsp_valid set
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes: 00 NOT a; 01 a AND b; 10 a OR b; 11 a NAND b. Pure bitwise, no carry, result WIDTH bits.
- FSM states IDLE, EXEC, RESP.
- IDLE: if any req_valid, arbiter selects winner w; req_ready[w]=1 combinationally that cycle; on clock edge op/a/b of w and w itself are registered, go EXEC. No valid: stay IDLE, req_ready all 0.
- EXEC: logic unit evaluates captured operands; result registered into rsp_data; go RESP. req_ready all 0.
- RESP: rsp_valid[w]=1, rsp_data stable. On rsp_ready[w]=1: go IDLE, arbitration pointer = w+1 (mod NUM_REQ). rsp_ready of other requesters ignored. req_ready all 0.
- Requesters hold req_valid/op/a/b until accepted; a valid dropped before acceptance is simply not considered in the next IDLE cycle.
- Reset (any state, any time): state IDLE, pointer 0, req_ready 0, rsp_valid 0, rsp_data 0, busy 0; in-flight operation discarded, no response issued.

## Timing
- Accept in cycle T (req_valid[w]&req_ready[w]); rsp_valid[w] rises at start of T+2.
- Response handshake in cycle R; earliest next accept R+1. Minimum 3 cycles per operation.
- rsp_ready may be high before rsp_valid; handshake completes first RESP cycle.
- rsp_ready held low: stays in RESP indefinitely, data stable, no new grants.
- Arbitration is evaluated only in IDLE; request arriving during EXEC/RESP waits.

## Configuration
- BITOP16_ARB_RR_EN defined: round-robin arbitration, search starts at pointer, pointer updated as above; no requester starves.
- Undefined: fixed priority, lowest index wins; pointer register removed.

## Structure
- Shared package bitop16_pkg: opcode constants (OP_NOT, OP_AND, OP_OR, OP_NAND), FSM state encoding, default NUM_REQ/WIDTH.
- One sub-module: bitop16_rr_arbiter (combinational grant from req_valid and pointer, one-hot output; fixed-priority when macro undefined).
- The 16-bit logic unit is the existing gate-level datapath, instantiated once.

## Test plan
- Requester 0, NOT a=25 -> rsp_valid[0] at T+2, rsp_data=16'hFFE6 (signed -26).
- Requester 2, NOT a=4181 (16'h1055) -> rsp_data=16'hEFAA; AND 16'h00FF,16'h0F0F -> 16'h000F; NAND same -> 16'hFFF0; OR -> 16'h0FFF.
- All four requesters valid continuously from reset, rsp_ready tied 1 -> grant order 0,1,2,3,0 with macro; 0,0,0 without.
- rsp_ready[w] held low 10 cycles with other requests pending -> rsp_valid[w] and rsp_data constant, req_ready all 0, busy 1; release -> IDLE next cycle.
- rst_n pulsed low during EXEC -> outputs 0 immediately, no rsp_valid afterwards for that op, pointer back to 0.
- req_valid[1] raised then dropped before IDLE -> never granted, no response.
